// File: rtl/div_reconstruct_pkg.sv
// Shared encodings and widths for the quotient/remainder reconstruction unit.
// Also used by the self-check path that sits beside the restoring divider.
package div_reconstruct_pkg;

  localparam int N_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    ADDR = 2'd2,
    DONE = 2'd3
  } state_t;

  // A counter must still be at least one bit wide when N is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/div_reconstruct_shift_acc.sv
// {A,Q} shift-add accumulator: parallel load, conditional add of m into A, right shift.
// One iteration per cycle while step is high; load takes priority; no backpressure.
module div_reconstruct_shift_acc
  import div_reconstruct_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   q,
  input  logic [N-1:0]   m,
  output logic [2*N-1:0] prod
);

  logic [2*N:0] acc;
  logic [N:0]   sum;

  // A[N] is always 0 before the add, so A + M never carries out of N+1 bits.
  always_comb begin
    sum = acc[2*N:N];
    if (acc[0]) begin
      sum = acc[2*N:N] + {1'b0, m};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= {{(N+1){1'b0}}, q};
    end else if (step) begin
      acc <= {1'b0, sum, acc[N-1:1]};
    end
  end

  assign prod = acc[2*N-1:0];

endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds the dividend x = q*d + w by shift-add, with divide-by-zero and remainder-range flags.
// done pulses N+2 cycles after start is accepted; start is ignored unless IDLE.
module div_reconstruct
  import div_reconstruct_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   q,
  input  logic [N-1:0]   d,
  input  logic [N-1:0]   w,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] x,
  output logic           divBy0,
  output logic           remErr
);

  localparam int CW = cnt_width(N);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    m_reg;
  logic [N-1:0]    r_reg;
  logic [2*N-1:0]  prod;
  logic            acc_load;
  logic            acc_step;

  assign acc_load = (state == IDLE) && start;
  assign acc_step = (state == STEP);

  div_reconstruct_shift_acc #(.N(N)) u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (acc_load),
    .step (acc_step),
    .q    (q),
    .m    (m_reg),
    .prod (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      m_reg  <= '0;
      r_reg  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      x      <= '0;
      divBy0 <= 1'b0;
      remErr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg  <= d;
            r_reg  <= w;
            divBy0 <= (d == '0);
            remErr <= (d != '0) && (w >= d);
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= STEP;
          end
        end
        STEP: begin
          if (cnt == CW'(N-1)) begin
            state <= ADDR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ADDR: begin
          // The sum peaks at 2^2N - 2^N, so the 2N-bit result never wraps.
          x     <= prod + {{N{1'b0}}, r_reg};
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_reconstruct.sv
// Randomised scoreboard bench for div_reconstruct against an arithmetic reference.
module tb_div_reconstruct;

  localparam int N = 5;

  typedef struct {
    int x;
    int dz;
    int re;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   q = '0;
  logic [N-1:0]   d = '0;
  logic [N-1:0]   w = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] x;
  logic           divBy0;
  logic           remErr;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];
  logic prev_done = 1'b0;

  div_reconstruct #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .q      (q),
    .d      (d),
    .w      (w),
    .busy   (busy),
    .done   (done),
    .x      (x),
    .divBy0 (divBy0),
    .remErr (remErr)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int qv, input int dv, input int wv);
    exp_t e;
    e.x  = qv * dv + wv;
    e.dz = (dv == 0) ? 1 : 0;
    e.re = (dv != 0 && wv >= dv) ? 1 : 0;
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_single_cycle", int'(prev_done), 0);
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("x", int'(x), e.x);
          chk("divBy0", int'(divBy0), e.dz);
          chk("remErr", int'(remErr), e.re);
        end
      end
      prev_done = done;
    end
  end

  // Caller is at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_op(input int qv, input int dv, input int wv, input exp_t e);
    int lat;
    int busy_ok;
    q     = N'(qv);
    d     = N'(dv);
    w     = N'(wv);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sbq.push_back(e);
    q = N'($urandom);
    d = N'($urandom);
    w = N'($urandom);
    lat     = 0;
    busy_ok = 1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, N + 1);
    chk("busy_while_running", busy_ok, 1);
    chk("busy_low_at_done", int'(busy), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    exp_t e;
    int   wv;
    int   x0;
    int   dv;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_divBy0", int'(divBy0), 0);
    chk("rst_remErr", int'(remErr), 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(13, 7, 4, model(13, 7, 4));
    run_op(31, 31, 30, model(31, 31, 30));
    run_op(0, 9, 3, model(0, 9, 3));
    run_op(5, 0, 0, model(5, 0, 0));
    run_op(2, 3, 3, model(2, 3, 3));

    // start held high through busy and DONE; input change after accept is ignored
    q = 5'd6; d = 5'd5; w = 5'd1; start = 1'b1;
    @(posedge clk);
    sbq.push_back(model(6, 5, 1));
    sbq.push_back(model(1, 1, 0));
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    q = 5'd1; d = 5'd1; w = 5'd0;
    wait_done("hold_first_done");
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_not_busy", int'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hold_second_accept", int'(busy), 1);
    wait_done("hold_second_done");
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of STEP aborts without a done pulse
    q = 5'd10; d = 5'd10; w = 5'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_x", int'(x), 0);
    chk("abort_divBy0", int'(divBy0), 0);
    chk("abort_remErr", int'(remErr), 0);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    run_op(10, 10, 0, model(10, 10, 0));

    // Full q,d sweep with a random legal remainder
    for (int qi = 0; qi < 32; qi++) begin
      for (int di = 0; di < 32; di++) begin
        wv = (di == 0) ? 0 : int'($urandom_range(di - 1, 0));
        run_op(qi, di, wv, model(qi, di, wv));
      end
    end

    // Chained with division: the rebuilt value must be the original dividend
    for (int k = 0; k < 200; k++) begin
      dv   = int'($urandom_range(31, 1));
      x0   = int'($urandom_range(dv * 32 - 1, 0));
      e.x  = x0;
      e.dz = 0;
      e.re = 0;
      run_op(x0 / dv, dv, x0 % dv, e);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_reconstruct.md
Name: div_reconstruct

Overview:
- Sequential shift-add unit that runs the divider in reverse: takes quotient q, divisor d and remainder w, and rebuilds the dividend x = q*d + w.
- Sits beside the restoring-division datapath. Feeding the divider's q/w outputs and its d input gives a self-check path: the rebuilt value must equal the original dividend.
- Controller and datapath live in one module, with a start/done handshake like the adder and two's-complement blocks.

Parameters:
- N, 5, operand width; result width is 2N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  begin operation; sampled only in IDLE
- q  input  N  quotient, unsigned
- d  input  N  divisor, unsigned
- w  input  N  remainder, unsigned
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when x is valid
- x  output  2N  reconstructed dividend q*d + w
- divBy0  output  1  d was 0 at accept
- remErr  output  1  d != 0 and w >= d at accept

Behaviour:
- Reset (rst==0 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, x=0, divBy0=0, remErr=0.
  - Internal A/Q/M/R registers and the step counter are cleared.
  - Reset overrides start.
  - Reset during STEP or ADDR aborts the operation: no done pulse, x=0.
- All arithmetic is unsigned. Max result is (2^N-1)^2 + (2^N-1) = 2^2N - 2^N, so it always fits in 2N bits and no overflow flag exists.
- IDLE:
  - start==1 at an edge:
    - Latch Q<=q, M<=d, R<=w, A<=0 (N+1 bits).
    - Set divBy0 and remErr from the inputs; both flags hold until the next accept.
    - cnt<=0, go to STEP.
  - start==0: stay in IDLE; x and the flags hold their last values.
- STEP, one iteration per cycle, N iterations:
  - If Q[0]==1, A <= A + {0,M}; else A is unchanged.
  - Then shift {A,Q} right one bit with 0 into A[N], in the same edge.
  - Stay in STEP while cnt < N-1, incrementing cnt. On the iteration with cnt==N-1, go to ADDR.
- ADDR:
  - x <= {A[N-1:0],Q} + {0,R}, truncated to 2N bits (never truncates in practice).
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle, busy=0, then go to IDLE.
  - start asserted in DONE is ignored; a new operation needs start in IDLE.
- Latency, with start sampled at edge k:
  - busy=1 from after edge k through edge k+N+1.
  - done high in the cycle after edge k+N+1, i.e. N+2 cycles after accept (7 for N=5).
  - Back-to-back throughput: one result per N+3 cycles.
- start while busy is ignored. Input changes after accept have no effect.
- divBy0 and remErr are advisory only: x is still computed. For d=0 the result is w.
- x changes only in ADDR and on reset.

Decomposition:
- Shared package:
  - State encoding constants IDLE/STEP/ADDR/DONE.
  - Default width N=5.
  - Counter width clog2(N).
- One natural sub-module, shift_acc:
  - Holds the (2N+1)-bit {A,Q} register with parallel load, conditional add of M into A, and a combined right shift.
  - Mirrors the reg6bit/reg5bit pair in the divider.
- FSM, counter, flag logic and the final remainder add stay in div_reconstruct.

Test Plan:
- q=13, d=7, w=4, pulse start → done exactly 7 cycles after the accept edge; x=95; divBy0=0; remErr=0; busy high for the 6 cycles between.
- q=31, d=31, w=30 → x=991; no flags. Then q=0, d=9, w=3 → x=3.
- q=5, d=0, w=0 → x=0, divBy0=1, remErr=0. Next, q=2, d=3, w=3 → x=9, remErr=1, divBy0=0.
- q=6, d=5, w=1 accepted; start held high through busy and DONE, with inputs changed to q=1, d=1, w=0 at cycle 2 → first x=31, single done pulse. The second operation starts only on the IDLE cycle after DONE and yields x=1.
- q=10, d=10, w=0 started; rst=0 for one cycle at STEP iteration 3 → next cycle busy=0, done=0, x=0, flags 0; no done pulse ever appears. Restart with the same inputs → x=100.
- Random sweep of all q,d in 0..31 with w<d (or w=0 when d=0), chained with the division datapath where the dividend is in range → x equals the original dividend in every case.
